// File: rtl/io_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : io_capture_fifo
//  Purpose  : Multi-channel capture of CPU I/O write strobes into per-channel
//             pending slots, fixed-priority arbitration into a shared FIFO,
//             valid/ready drain, sticky overflow flag and saturating drop count.
//  Revision : 1.0  initial release
// ============================================================================
module io_capture_fifo #(
  parameter int DATA_W     = 64,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 8,
  parameter int LEVEL_MODE = 0,
  localparam int C_CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int C_CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          io_write,
  input  logic [CHANNELS*DATA_W-1:0]   io_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [C_CHAN_W-1:0]          out_chan,
  output logic [C_CNT_W-1:0]           count,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt,
  input  logic                         clr_stat
);

  localparam int C_ADDR_W = $clog2(DEPTH);

  logic [CHANNELS-1:0] r_prev_write;
  logic [CHANNELS-1:0] r_pend_v;
  logic [DATA_W-1:0]   r_pend_d [CHANNELS];
  logic [CHANNELS-1:0] w_event;
  logic [CHANNELS-1:0] w_pend_clr;
  logic [CHANNELS-1:0] w_drop;

  logic [DATA_W-1:0]   r_mem_d [DEPTH];
  logic [C_CHAN_W-1:0] r_mem_c [DEPTH];
  logic [C_ADDR_W-1:0] r_wr_ptr;
  logic [C_ADDR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0]  r_count;
  logic                r_overflow;
  logic [15:0]         r_drop_cnt;

  logic [C_CHAN_W-1:0] w_grant;
  logic                w_any_pend;
  logic                w_full;
  logic                w_deq;
  logic                w_enq;
  logic [3:0]          w_drop_num;
  logic [16:0]         w_drop_sum;
  logic [15:0]         w_drop_sat;

  // Event source: edge detect against last cycle's strobe, or raw level.
  if (LEVEL_MODE != 0) begin : g_level
    assign w_event = io_write;
  end else begin : g_edge
    assign w_event = io_write & ~r_prev_write;
  end

  assign w_full    = (r_count == C_CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_deq     = out_valid & out_ready;
  // A full FIFO can still accept when its head leaves in the same cycle.
  assign w_enq     = w_any_pend & (~w_full | w_deq);

  // Fixed priority: scan downwards so the lowest pending index wins.
  always_comb begin
    w_grant    = '0;
    w_any_pend = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (r_pend_v[c]) begin
        w_grant    = C_CHAN_W'(c);
        w_any_pend = 1'b1;
      end
    end
  end

  // Per-channel strobe history and pending slot.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign w_pend_clr[c] = w_enq & (w_grant == C_CHAN_W'(c));
    // A capture is lost only when the slot is occupied and not leaving now.
    assign w_drop[c]     = w_event[c] & r_pend_v[c] & ~w_pend_clr[c];

    // Track strobe and hold the captured word until it reaches the FIFO.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_prev_write[c] <= 1'b0;
        r_pend_v[c]     <= 1'b0;
        r_pend_d[c]     <= '0;
      end else begin
        r_prev_write[c] <= io_write[c];
        if (w_event[c] && !w_drop[c]) begin
          r_pend_v[c] <= 1'b1;
          r_pend_d[c] <= io_data[c*DATA_W +: DATA_W];
        end else if (w_pend_clr[c]) begin
          r_pend_v[c] <= 1'b0;
        end
      end
    end
  end

  // Number of captures lost this cycle, and the saturated running total.
  always_comb begin
    w_drop_num = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_drop_num = w_drop_num + 4'(w_drop[c]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);
    w_drop_sat = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  // FIFO storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_d[r_wr_ptr] <= r_pend_d[w_grant];
      r_mem_c[r_wr_ptr] <= w_grant;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
      else if (!w_enq && w_deq) r_count <= r_count - 1'b1;
    end
  end

  // Loss statistics; a clear still records drops occurring in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr_stat) begin
      r_overflow <= (w_drop_num != '0);
      r_drop_cnt <= 16'(w_drop_num);
    end else begin
      r_overflow <= r_overflow | (w_drop_num != '0);
      r_drop_cnt <= w_drop_sat;
    end
  end

  assign out_data = out_valid ? r_mem_d[r_rd_ptr] : '0;
  assign out_chan = out_valid ? r_mem_c[r_rd_ptr] : '0;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
